morningjava_sqrt_arbiter: RTL

- Round-robin arbiter that shares the pipelined `morningjava_sqrt` unit between G_REQUESTERS clients.
- Each client gets a valid/ready request handshake. The arbiter issues at most one operand per clock and tracks ownership through a shadow tag pipeline matching the sqrt latency.
- Each result is routed back to its owner as a one-cycle response pulse.
- Holds the most recent result and its owner for `morningjava_seg7`.

---
 rtl/morningjava_sqrt_arbiter_if.sv | 29 ++
 rtl/morningjava_sqrt_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/morningjava_sqrt_arbiter_if.sv
// Client/sqrt-side bundle of the round-robin sqrt arbiter.
// master: clients plus the sqrt unit; slave: the arbiter itself.
interface morningjava_sqrt_arbiter_if #(
    parameter int G_REQUESTERS = 4,
    parameter int G_WIDTH      = 8,
    parameter int G_LATENCY    = 4
);
    logic                              enable;
    logic [G_REQUESTERS-1:0]           req_valid;
    logic [G_REQUESTERS*G_WIDTH-1:0]   req_data;
    logic [G_REQUESTERS-1:0]           req_ready;
    logic [G_WIDTH-1:0]                sq_data;
    logic [G_WIDTH/2-1:0]              sq_result;
    logic [G_REQUESTERS-1:0]           rsp_valid;
    logic [G_WIDTH/2-1:0]              rsp_data;
    logic [G_WIDTH/2-1:0]              disp_data;
    logic [$clog2(G_REQUESTERS)-1:0]   disp_owner;
    logic [$clog2(G_LATENCY+2)-1:0]    inflight;

    modport master (
        output enable, req_valid, req_data, sq_result,
        input  req_ready, sq_data, rsp_valid, rsp_data, disp_data, disp_owner, inflight
    );

    modport slave (
        input  enable, req_valid, req_data, sq_result,
        output req_ready, sq_data, rsp_valid, rsp_data, disp_data, disp_owner, inflight
    );
endinterface

// File: rtl/morningjava_sqrt_arbiter.sv
// Round-robin arbiter sharing one pipelined sqrt among several clients.
// Ownership of each in-flight operand travels in a shadow tag pipe; the sqrt
// itself has no valid or reset, so only the shadow pipe qualifies results.
module morningjava_sqrt_arbiter #(
    parameter int G_REQUESTERS = 4,
    parameter int G_WIDTH      = 8,
    parameter int G_LATENCY    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    morningjava_sqrt_arbiter_if.slave bus
);
    localparam int C_RW = G_WIDTH / 2;
    localparam int C_TW = $clog2(G_REQUESTERS);
    localparam int C_IW = $clog2(G_LATENCY + 2);

    logic [C_TW-1:0]               r_ptr;
    logic [G_WIDTH-1:0]            r_sq_data;
    // Stage 0 lines up with r_sq_data; stage G_LATENCY lines up with sq_result.
    logic [G_LATENCY:0]            r_sh_vld;
    logic [G_LATENCY:0][C_TW-1:0]  r_sh_tag;
    logic [G_REQUESTERS-1:0]       r_rsp_valid;
    logic [C_RW-1:0]               r_rsp_data;
    logic [C_RW-1:0]               r_disp_data;
    logic [C_TW-1:0]               r_disp_owner;
    logic [C_IW-1:0]               r_inflight;

    logic [G_REQUESTERS-1:0]       w_grant;
    logic [C_TW-1:0]               w_grant_idx;
    logic [C_TW-1:0]               w_scan;
    logic                          w_issue;
    logic [G_WIDTH-1:0]            w_operand;
    logic                          w_retire;
    logic [C_TW-1:0]               w_retire_tag;

    // Search upward from the pointer; descending scan so the nearest requester wins.
    always_comb begin
        w_grant_idx = '0;
        w_scan      = '0;
        w_issue     = 1'b0;
        if (rst_n && bus.enable) begin
            for (int k = G_REQUESTERS - 1; k >= 0; k--) begin
                w_scan = r_ptr + C_TW'(k);
                if (bus.req_valid[w_scan]) begin
                    w_grant_idx = w_scan;
                    w_issue     = 1'b1;
                end
            end
        end
        w_grant = w_issue ? (G_REQUESTERS'(1) << w_grant_idx) : '0;
    end

    assign w_operand    = bus.req_data[w_grant_idx*G_WIDTH +: G_WIDTH];
    assign w_retire     = r_sh_vld[G_LATENCY];
    assign w_retire_tag = r_sh_tag[G_LATENCY];

    // Issue side: capture the operand, advance the pointer, shift the shadow pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_sq_data <= '0;
            r_sh_vld  <= '0;
            r_sh_tag  <= '0;
        end else begin
            r_sh_vld <= {r_sh_vld[G_LATENCY-1:0], w_issue};
            r_sh_tag <= {r_sh_tag[G_LATENCY-1:0], w_grant_idx};
            if (w_issue) begin
                r_sq_data <= w_operand;
                r_ptr     <= w_grant_idx + C_TW'(1);
            end
        end
    end

    // Retire side: one-cycle pulse to the owner, and hold the last result for display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
            r_disp_data  <= '0;
            r_disp_owner <= '0;
        end else begin
            r_rsp_valid <= w_retire ? (G_REQUESTERS'(1) << w_retire_tag) : '0;
            if (w_retire) begin
                r_rsp_data   <= bus.sq_result;
                r_disp_data  <= bus.sq_result;
                r_disp_owner <= w_retire_tag;
            end
        end
    end

    // Outstanding-operation count; bounded by the shadow depth so it cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue, w_retire})
                2'b10:   r_inflight <= r_inflight + C_IW'(1);
                2'b01:   r_inflight <= r_inflight - C_IW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign bus.req_ready  = w_grant;
    assign bus.sq_data    = r_sq_data;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.disp_data  = r_disp_data;
    assign bus.disp_owner = r_disp_owner;
    assign bus.inflight   = r_inflight;
endmodule
